// File: rtl/reaction_game_ctrl_pkg.sv
// reaction_game_ctrl_pkg: state and winner codes shared by the reaction game sequencer.
package reaction_game_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT      = 3'd1,
    ST_GO        = 3'd2,
    ST_RESULT    = 3'd3,
    ST_FOUL      = 3'd4,
    ST_MATCH_END = 3'd5
  } state_e;
  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_A    = 2'b01,
    WIN_B    = 2'b10,
    WIN_TIE  = 2'b11
  } win_e;
endpackage

// File: rtl/reaction_game_ctrl_btn_rise.sv
// btn_rise: rising-edge detector whose history resets high so a button held through reset gives no edge.
module btn_rise (
  input  logic clk_in,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  logic prev_q, prev_d;
  always_comb prev_d = btn;
  always_ff @(posedge clk_in) prev_q <= rst ? 1'b1 : prev_d;
  assign rise = btn & ~prev_q;
endmodule

// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: round sequencer, ms prescaler, arm delay, reaction timer and match scoring.
module reaction_game_ctrl
  import reaction_game_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int ARM_DELAY_MS = 2000,
  parameter int MAX_MS       = 999,
  parameter int SCORE_MAX    = 9
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_start,
  output logic       count_clr,
  output logic       count_en,
  output logic       ms_tick,
  output logic [9:0] elapsed_ms,
  output logic [1:0] winner,
  output logic       false_start,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [2:0] state_o
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(ARM_DELAY_MS + 1);
  state_e        state_q, state_d;
  win_e          win_q, win_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [9:0]    el_q, el_d;
  logic [3:0]    sa_q, sa_d, sb_q, sb_d;
  logic          clr_q, clr_d, mst_q, mst_d, en_q, en_d, fs_q, fs_d;
  logic          rise_a, rise_b, rise_s, run, tick, pt_a, pt_b;
  btn_rise u_rise_a (.clk_in(clk_in), .rst(rst), .btn(btn_a),     .rise(rise_a));
  btn_rise u_rise_b (.clk_in(clk_in), .rst(rst), .btn(btn_b),     .rise(rise_b));
  btn_rise u_rise_s (.clk_in(clk_in), .rst(rst), .btn(btn_start), .rise(rise_s));
  assign run  = state_q == ST_WAIT || state_q == ST_GO;
  assign tick = run && pre_q == PW'(TICK_DIV - 1);
  // In WAIT a press is a foul, so the point goes to the opponent.
  assign pt_a = state_q == ST_GO ? rise_a & ~rise_b : rise_b & ~rise_a;
  assign pt_b = state_q == ST_GO ? rise_b & ~rise_a : rise_a & ~rise_b;
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    el_d    = el_q;
    dly_d   = dly_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    clr_d   = 1'b0;
    mst_d   = 1'b0;
    pre_d   = tick ? '0 : run ? pre_q + 1'b1 : pre_q;
    case (state_q)
      ST_IDLE, ST_RESULT, ST_FOUL:
        if (rise_s) begin
          state_d = ST_WAIT;
          win_d   = WIN_NONE;
          el_d    = '0;
          dly_d   = '0;
          pre_d   = '0;
          clr_d   = 1'b1;
        end
      ST_WAIT, ST_GO:
        if (rise_a | rise_b) begin
          win_d   = pt_a ? WIN_A : pt_b ? WIN_B : WIN_TIE;
          sa_d    = sa_q + 4'(pt_a);
          sb_d    = sb_q + 4'(pt_b);
          state_d = (pt_a && sa_d == 4'(SCORE_MAX)) || (pt_b && sb_d == 4'(SCORE_MAX)) ? ST_MATCH_END :
                    state_q == ST_GO ? ST_RESULT : ST_FOUL;
        end else if (state_q == ST_GO) begin
          if (el_q == 10'(MAX_MS)) begin
            state_d = ST_RESULT;
            win_d   = WIN_NONE;
          end else if (tick) begin
            mst_d = 1'b1;
            el_d  = el_q + 1'b1;
          end
        end else if (tick) begin
          dly_d = dly_q + 1'b1;
          if (dly_q == DW'(ARM_DELAY_MS - 1)) begin
            state_d = ST_GO;
            pre_d   = '0;
          end
        end
      ST_MATCH_END:
        if (rise_s) begin
          state_d = ST_IDLE;
          win_d   = WIN_NONE;
          el_d    = '0;
          sa_d    = '0;
          sb_d    = '0;
        end
      default: state_d = ST_IDLE;
    endcase
    en_d = state_d == ST_GO;
    fs_d = state_d == ST_FOUL;
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
      win_q   <= WIN_NONE;
      pre_q   <= '0;
      dly_q   <= '0;
      el_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      clr_q   <= 1'b0;
      mst_q   <= 1'b0;
      en_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pre_q   <= pre_d;
      dly_q   <= dly_d;
      el_q    <= el_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      clr_q   <= clr_d;
      mst_q   <= mst_d;
      en_q    <= en_d;
      fs_q    <= fs_d;
    end
  end
  assign count_clr   = clr_q;
  assign count_en    = en_q;
  assign ms_tick     = mst_q;
  assign elapsed_ms  = el_q;
  assign winner      = win_q;
  assign false_start = fs_q;
  assign score_a     = sa_q;
  assign score_b     = sb_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// tb_reaction_game_ctrl: scenario tasks push expected snapshots to a scoreboard checked when the DUT settles.
module tb_reaction_game_ctrl;
  logic       clk_in = 1'b0, rst = 1'b1, btn_a = 1'b0, btn_b = 1'b0, btn_start = 1'b0;
  logic       count_clr, count_en, ms_tick, false_start;
  logic [9:0] elapsed_ms;
  logic [1:0] winner;
  logic [3:0] score_a, score_b;
  logic [2:0] state_o;
  int nchk = 0, nbad = 0;
  typedef struct packed {
    logic [2:0] st;
    logic [1:0] win;
    logic [3:0] sa;
    logic [3:0] sb;
    logic [9:0] el;
    logic       fs;
    logic       en;
  } exp_t;
  exp_t  exq[$];
  string nmq[$];
  reaction_game_ctrl #(.TICK_DIV(4), .ARM_DELAY_MS(3), .MAX_MS(10), .SCORE_MAX(2)) dut (
    .clk_in(clk_in), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .btn_start(btn_start),
    .count_clr(count_clr), .count_en(count_en), .ms_tick(ms_tick), .elapsed_ms(elapsed_ms),
    .winner(winner), .false_start(false_start), .score_a(score_a), .score_b(score_b),
    .state_o(state_o)
  );
  always #5 clk_in = ~clk_in;
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask
  task automatic push(input string nm, input logic [2:0] st, input logic [1:0] w,
                      input logic [3:0] a, input logic [3:0] b, input logic [9:0] el,
                      input logic fs, input logic en);
    exp_t e;
    e = '{st: st, win: w, sa: a, sb: b, el: el, fs: fs, en: en};
    exq.push_back(e);
    nmq.push_back(nm);
  endtask
  task automatic sb_check();
    exp_t  e;
    string nm;
    if (exq.size() == 0) begin
      nchk++; nbad++;
      $display("FAIL scoreboard_empty got=0 entries exp>=1");
      return;
    end
    e  = exq.pop_front();
    nm = nmq.pop_front();
    nchk++; if (state_o !== e.st) begin nbad++; $display("FAIL %s state_o got=%0d exp=%0d", nm, state_o, e.st); end
    nchk++; if (winner !== e.win) begin nbad++; $display("FAIL %s winner got=%b exp=%b", nm, winner, e.win); end
    nchk++; if (score_a !== e.sa) begin nbad++; $display("FAIL %s score_a got=%0d exp=%0d", nm, score_a, e.sa); end
    nchk++; if (score_b !== e.sb) begin nbad++; $display("FAIL %s score_b got=%0d exp=%0d", nm, score_b, e.sb); end
    nchk++; if (elapsed_ms !== e.el) begin nbad++; $display("FAIL %s elapsed_ms got=%0d exp=%0d", nm, elapsed_ms, e.el); end
    nchk++; if (false_start !== e.fs) begin nbad++; $display("FAIL %s false_start got=%b exp=%b", nm, false_start, e.fs); end
    nchk++; if (count_en !== e.en) begin nbad++; $display("FAIL %s count_en got=%b exp=%b", nm, count_en, e.en); end
  endtask
  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    while (state_o !== s && n < budget) begin
      cyc();
      n++;
    end
    nchk++;
    if (state_o !== s) begin nbad++; $display("FAIL %s wait_state got=%0d exp=%0d", nm, state_o, s); end
  endtask
  task automatic do_reset();
    rst = 1'b1; btn_a = 1'b0; btn_b = 1'b0; btn_start = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc();
  endtask
  task automatic start_round();
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
  endtask
  task automatic press(input logic a, input logic b);
    btn_a = a; btn_b = b;
    cyc();
    btn_a = 1'b0; btn_b = 1'b0;
  endtask
  task automatic test_reset();
    btn_a = 1'b1; rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    push("reset", 0, 0, 0, 0, 0, 0, 0);
    sb_check();
    nchk++; if (count_clr !== 1'b0 || ms_tick !== 1'b0) begin nbad++; $display("FAIL reset_pulses got=%b%b exp=00", count_clr, ms_tick); end
    push("idle_to_wait", 1, 0, 0, 0, 0, 0, 0);
    start_round();
    sb_check();
    nchk++; if (count_clr !== 1'b1) begin nbad++; $display("FAIL clr_pulse got=%b exp=1", count_clr); end
    cyc();
    nchk++; if (count_clr !== 1'b0) begin nbad++; $display("FAIL clr_width got=%b exp=0", count_clr); end
    cyc(8);
    nchk++; if (state_o !== 3'd1 || false_start !== 1'b0) begin nbad++; $display("FAIL held_btn got=%0d/%b exp=1/0", state_o, false_start); end
    btn_a = 1'b0;
  endtask
  task automatic test_a_hit();
    int n = 0;
    do_reset();
    start_round();
    cyc(11);
    nchk++; if (state_o !== 3'd1) begin nbad++; $display("FAIL arm_early got=%0d exp=1", state_o); end
    cyc();
    nchk++; if (state_o !== 3'd2 || count_en !== 1'b1) begin nbad++; $display("FAIL arm_go got=%0d/%b exp=2/1", state_o, count_en); end
    while (elapsed_ms !== 10'd5 && n < 40) begin cyc(); n++; end
    nchk++; if (elapsed_ms !== 10'd5) begin nbad++; $display("FAIL reach_5ms got=%0d exp=5", elapsed_ms); end
    push("a_hit", 3, 1, 1, 0, 5, 0, 0);
    press(1'b1, 1'b0);
    sb_check();
    cyc(9);
    nchk++; if (elapsed_ms !== 10'd5 || winner !== 2'b01) begin nbad++; $display("FAIL result_hold got=%0d/%b exp=5/01", elapsed_ms, winner); end
  endtask
  task automatic test_fouls();
    do_reset();
    start_round();
    cyc(5);
    push("foul_b", 4, 1, 1, 0, 0, 1, 0);
    press(1'b0, 1'b1);
    sb_check();
    push("rearm_1", 1, 0, 1, 0, 0, 0, 0);
    start_round();
    sb_check();
    nchk++; if (count_clr !== 1'b1) begin nbad++; $display("FAIL rearm_clr got=%b exp=1", count_clr); end
    cyc(2);
    push("foul_a", 4, 2, 1, 1, 0, 1, 0);
    press(1'b1, 1'b0);
    sb_check();
    push("rearm_2", 1, 0, 1, 1, 0, 0, 0);
    start_round();
    sb_check();
    cyc();
    start_round();
    nchk++; if (state_o !== 3'd1) begin nbad++; $display("FAIL start_in_wait got=%0d exp=1", state_o); end
    push("foul_tie", 4, 3, 1, 1, 0, 1, 0);
    press(1'b1, 1'b1);
    sb_check();
  endtask
  task automatic test_timeout();
    int n = 0, ticks = 0;
    do_reset();
    start_round();
    wait_state(3'd2, 20, "to_go");
    push("timeout", 3, 0, 0, 0, 10, 0, 0);
    while (state_o === 3'd2 && n < 80) begin
      cyc();
      n++;
      if (ms_tick === 1'b1) ticks++;
    end
    nchk++; if (ticks != 10) begin nbad++; $display("FAIL ms_tick_count got=%0d exp=10", ticks); end
    sb_check();
    push("rearm_to", 1, 0, 0, 0, 0, 0, 0);
    start_round();
    sb_check();
    wait_state(3'd2, 20, "to_go_2");
    push("go_tie", 3, 3, 0, 0, 0, 0, 0);
    press(1'b1, 1'b1);
    sb_check();
  endtask
  task automatic test_match();
    do_reset();
    start_round();
    wait_state(3'd2, 20, "m_go_1");
    push("match_r1", 3, 1, 1, 0, 0, 0, 0);
    press(1'b1, 1'b0);
    sb_check();
    push("match_rearm", 1, 0, 1, 0, 0, 0, 0);
    start_round();
    sb_check();
    wait_state(3'd2, 20, "m_go_2");
    push("match_end", 5, 1, 2, 0, 0, 0, 0);
    press(1'b1, 1'b0);
    sb_check();
    cyc(3);
    push("match_hold", 5, 1, 2, 0, 0, 0, 0);
    sb_check();
    push("match_clear", 0, 0, 0, 0, 0, 0, 0);
    start_round();
    sb_check();
  endtask
  task automatic test_reset_mid_go();
    do_reset();
    start_round();
    wait_state(3'd2, 20, "rm_go_1");
    push("rm_score", 3, 1, 1, 0, 0, 0, 0);
    press(1'b1, 1'b0);
    sb_check();
    start_round();
    wait_state(3'd2, 20, "rm_go_2");
    cyc(6);
    nchk++; if (count_en !== 1'b1 || elapsed_ms !== 10'd1) begin nbad++; $display("FAIL rm_running got=%b/%0d exp=1/1", count_en, elapsed_ms); end
    push("reset_mid_go", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    sb_check();
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_a_hit();
    test_fouls();
    test_timeout();
    test_match();
    test_reset_mid_go();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
- Round sequencer for the two-player reaction game datapath.
- Player inputs A and B, start input C.
- Drives the reaction-time counter (clear/enable/ms tick), decides each round's winner or foul, and keeps per-player match scores.
- Exports the game state so the LED muxer can choose between the start-position pattern, the elapsed time and the scores.

Parameters:
- TICK_DIV, 50000: clk_in cycles per 1 ms tick.
- ARM_DELAY_MS, 2000: ms from round start until GO.
- MAX_MS, 999: reaction timeout in ms; must be ≤ 1023.
- SCORE_MAX, 9: points needed to win the match; must be ≤ 15.

Ports:
- clk_in  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- btn_a  in  1  player A level, already synchronized/debounced.
- btn_b  in  1  player B level, already synchronized/debounced.
- btn_start  in  1  start/next level, already synchronized/debounced.
- count_clr  out  1  one-cycle pulse that clears the external reaction counter.
- count_en  out  1  high only in GO.
- ms_tick  out  1  one-cycle pulse per ms while count_en is high.
- elapsed_ms  out  10  ms counted in the current GO phase.
- winner  out  2  00 none, 01 A, 10 B, 11 tie.
- false_start  out  1  high in FOUL.
- score_a  out  4  player A match score.
- score_b  out  4  player B match score.
- state_o  out  3  current state code, for the LED muxer.

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk_in.
  - Reset is synchronous and active-high.
  - Reset values: state IDLE, all outputs 0, prescaler 0.
  - Button history registers reset to 1, so a button held through reset produces no edge.
- Edges:
  - rise_x = btn_x & ~prev_x, evaluated every cycle.
  - All outputs are registered and take effect on the clock edge that samples the rise (latency 1).
- States (state_o encoding): IDLE=0, WAIT=1, GO=2, RESULT=3, FOUL=4, MATCH_END=5. Codes 6–7 are illegal and recover to IDLE on the next cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in WAIT and GO, and wraps at TICK_DIV-1.
  - The internal tick fires on the wrap cycle.
  - Cleared on every entry to WAIT or GO.
- IDLE:
  - rise_start → WAIT.
  - Same cycle: count_clr=1, winner=00, elapsed_ms=0, delay counter=0.
  - A/B rises are ignored.
- WAIT:
  - The delay counter increments on each tick.
  - On reaching ARM_DELAY_MS → GO, with count_en=1 from the next cycle.
  - Rise on A only → FOUL, winner=10, score_b+1.
  - Rise on B only → FOUL, winner=01, score_a+1.
  - A and B rise in the same cycle → FOUL, winner=11, no score change.
  - A rise coinciding with delay expiry takes priority: FOUL.
  - rise_start is ignored.
- GO:
  - Each tick: ms_tick=1 and elapsed_ms+1.
  - First A rise → RESULT, winner=01, score_a+1.
  - First B rise → RESULT, winner=10, score_b+1.
  - Both in the same cycle → winner=11, no score change.
  - When elapsed_ms reaches MAX_MS and no rise occurs in that cycle → RESULT, winner=00.
  - A rise in the timeout cycle counts as a hit.
  - count_en drops on the transition edge and elapsed_ms freezes.
- Scoring:
  - A score increment that makes the score equal SCORE_MAX sends the FSM to MATCH_END instead of RESULT/FOUL.
  - winner is held in MATCH_END.
  - Scores never exceed SCORE_MAX.
- RESULT / FOUL:
  - Hold all outputs.
  - rise_start → WAIT, with the IDLE→WAIT actions except that scores are kept.
- MATCH_END:
  - rise_start → IDLE, clearing scores, winner and elapsed_ms.
- Reset mid-round: return to IDLE on the next edge with scores cleared; count_en drops immediately.

Decomposition:
- Shared package:
  - State codes ST_IDLE..ST_MATCH_END.
  - Winner codes WIN_NONE, WIN_A, WIN_B, WIN_TIE.
- Sub-module btn_rise: history register reset to 1 plus the rise pulse; instantiated three times.
- Prescaler, delay counter, elapsed counter and FSM stay in the top of this block.

Test Plan (TICK_DIV=4, ARM_DELAY_MS=3, MAX_MS=10, SCORE_MAX=2):
- Reset with btn_a held high, then release and start → no foul from the held button; state_o goes 0→1 one cycle after the start rise; count_clr pulses exactly 1 cycle.
- Start, wait 12 cycles, A rises at elapsed_ms=5 → state_o=3, winner=01, score_a=1, elapsed_ms frozen at 5, count_en=0.
- Start, B rises in WAIT after 6 cycles → state_o=4, false_start=1, winner=01, score_a+1.
- Start, no press → ms_tick pulses 10 times in GO, elapsed_ms=10, winner=00, state_o=3; A and B rising in the same cycle in GO gives winner=11 with scores unchanged.
- A wins two rounds → state_o=5 with score_a=2; start → state_o=0, scores 0.
- Assert rst mid-GO → next cycle state_o=0, count_en=0, scores 0.
